neuron_layer_pingpong: RTL

//  Double-buffered neuron-value store for one FC layer. Upstream writes neuron values by address into
//  the write bank; once every address is written, the bank swaps to the read side and is presented whole
//  to the next layer's MAC array. The consumer releases the read bank when done. Filling the next layer

---
 rtl/neuron_layer_pkg.sv | 7 +
 rtl/neuron_bank.sv | 20 ++
 rtl/neuron_layer_pingpong.sv | 96 +++++++++
 3 files changed

// File: rtl/neuron_layer_pkg.sv
// neuron_layer_pkg: shared FSM state and width helper for the ping-pong neuron layer
package neuron_layer_pkg;
  typedef enum logic {FILL, WAIT_SWAP} state_t;
  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/neuron_bank.sv
// neuron_bank: LAYER_SZ x SIZE register file, one write port, full parallel read
module neuron_bank
  import neuron_layer_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int LAYER_SZ = 120,
  parameter int ADDR_W = addr_width(LAYER_SZ)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             en,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [SIZE-1:0]                  data,
  output logic [0:LAYER_SZ-1][SIZE-1:0]    q
);
  // storage; en is only raised for in-range addresses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (en) q[addr] <= data;
endmodule

// File: rtl/neuron_layer_pingpong.sv
// neuron_layer_pingpong: double-buffered neuron store; fill one bank while the other is read
// Optional NEURON_LAYER_RELU_EN: negative inputs are stored as zero (ReLU on ingest).
module neuron_layer_pingpong
  import neuron_layer_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int LAYER_SZ = 120,
  localparam int ADDR_W = addr_width(LAYER_SZ)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [SIZE-1:0]                  wr_data,
  input  logic                             rd_release,
  output logic [0:LAYER_SZ-1][SIZE-1:0]    values,
  output logic                             values_valid,
  output logic [ADDR_W:0]                  fill_count,
  output logic                             err_addr
);
  localparam logic [ADDR_W:0] LAYER_CNT = (ADDR_W+1)'(LAYER_SZ);
  state_t state, state_nx;
  logic wr_bank, in_range, accept, wr_ok, is_new, swap;
  logic [LAYER_SZ-1:0] bitmap;
  logic [ADDR_W:0] cnt_nx;
  logic [SIZE-1:0] wdata;
  logic [0:LAYER_SZ-1][SIZE-1:0] bank_q [2];

  // write qualification, swap condition and next state
  always_comb begin
    wr_ready = state == FILL;
    in_range = {1'b0, wr_addr} < LAYER_CNT;
    accept = wr_valid && wr_ready && !clear;
    wr_ok = accept && in_range;
    is_new = wr_ok && !bitmap[wr_addr];
    cnt_nx = fill_count + {{ADDR_W{1'b0}}, is_new};
    swap = state == WAIT_SWAP && (!values_valid || rd_release) && !clear;
    state_nx = clear ? FILL
             : state == FILL ? ((wr_ok && cnt_nx == LAYER_CNT) ? WAIT_SWAP : FILL)
             : (swap ? FILL : WAIT_SWAP);
`ifdef NEURON_LAYER_RELU_EN
    wdata = wr_data[SIZE-1] ? '0 : wr_data;
`else
    wdata = wr_data;
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= FILL;
    else state <= state_nx;

  // fill tracking, bank ownership, read-valid and sticky address error
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bitmap <= '0;
      fill_count <= '0;
      values_valid <= 1'b0;
      err_addr <= 1'b0;
      wr_bank <= 1'b0;
    end else if (clear) begin
      bitmap <= '0;
      fill_count <= '0;
      values_valid <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      if (swap) begin
        wr_bank <= ~wr_bank;
        bitmap <= '0;
        fill_count <= '0;
        values_valid <= 1'b1;
      end else begin
        if (wr_ok) begin
          bitmap[wr_addr] <= 1'b1;
          fill_count <= cnt_nx;
        end
        if (rd_release) values_valid <= 1'b0;
      end
      if (accept && !in_range) err_addr <= 1'b1;
    end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    neuron_bank #(.SIZE(SIZE), .LAYER_SZ(LAYER_SZ), .ADDR_W(ADDR_W)) u_bank (
      .clk(clk),
      .reset_n(reset_n),
      .en(wr_ok && wr_bank == 1'(b)),
      .addr(wr_addr),
      .data(wdata),
      .q(bank_q[b])
    );
  end

  assign values = bank_q[~wr_bank];
endmodule
